mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-access stage directly downstream of the EX/MEM pipeline register.
- Consumes the MEM-stage ALU result (effective address), rs2 value (store data) and control, and issues one data-memory request per instruction.
- Holds the pipeline with `stall` until `dmem_resp` arrives, then formats load data and registers it into the MEM/WB outputs.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data word width in bits; fixed at 32 (byte lanes = DATA_W/8 = 4).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- load  in  1  MEM/WB advance enable from the hazard unit
- MEM_pc  in  32  PC of the MEM-stage instruction
- MEM_alu_out  in  32  effective address, or ALU result for non-memory instructions
- MEM_rs2_out  in  32  store data
- MEM_mem_read  in  1  instruction is a load
- MEM_mem_write  in  1  instruction is a store
- MEM_funct3  in  3  size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- flush  in  1  MEM-stage instruction squashed
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_address  out  32  word-aligned address ({addr[31:2], 2'b00})
- dmem_byte_enable  out  4  store lane mask
- dmem_wdata  out  32  lane-shifted store data
- dmem_rdata  in  32  read data, valid when `dmem_resp`=1
- dmem_resp  in  1  one-cycle completion pulse
- stall  out  1  freeze upstream stages and this stage's inputs
- WB_pc  out  32  registered PC
- WB_alu_out  out  32  registered ALU result
- WB_mem_rdata  out  32  registered formatted load data
- WB_valid  out  1  WB holds a live, unflushed instruction
- WB_misalign  out  1  only present with the optional feature

Behaviour:
- Reset: all outputs go to 0 and the FSM goes to IDLE. Asserting reset mid-request drops the request on the next edge; no response is awaited afterwards, because the memory side resets on the same signal.
- FSM states:
  - IDLE: no request outstanding.
  - REQ: request asserted, waiting for `dmem_resp`.
  - HOLD: response captured but `load`=0.
- Transitions:
  - IDLE→REQ when (`MEM_mem_read` | `MEM_mem_write`) & ~`flush` (and ~misaligned when the feature is enabled).
  - REQ→IDLE on `dmem_resp` & `load`.
  - REQ→HOLD on `dmem_resp` & ~`load`.
  - HOLD→IDLE when `load`=1.
- Request outputs:
  - `dmem_read`/`dmem_write` are combinational from the inputs in IDLE and REQ, so the request is visible in the first MEM cycle.
  - They stay stable until `dmem_resp`, and are deasserted in HOLD.
  - They are never both high.
- Stall: `stall` = request needed & ~`dmem_resp`. There is zero stall if `dmem_resp` arrives in the same cycle as the request.
- Store lanes: `dmem_byte_enable` = sb 0001<<addr[1:0]; sh 0011<<addr[1:0]; sw 1111. `dmem_wdata` = rs2 shifted left by 8*addr[1:0].
- Load format: select the byte/half at addr[1:0] from `dmem_rdata`. lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- Response capture: the formatted value is captured on `dmem_resp` into a holding register, used for the HOLD case.
- WB register: on `load` & ~`stall`, WB_* take MEM_*, and `WB_mem_rdata` takes the formatted data (live or held). `WB_valid` = ~`flush`.
- Load gating: `load`=1 with `stall`=1 does not advance WB. `load`=0 holds all WB outputs.
- Flush while in REQ: the request completes (memory-side protocol cannot be aborted), but WB captures `WB_valid`=0.
- Non-memory instruction: no request, no stall, `WB_mem_rdata`=0.
- Misaligned address without the feature: lanes are computed from addr[1:0]; any lanes shifted beyond bit 3 are dropped.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]≠0, issues no memory request and no stall.
  - `WB_misalign` is registered as 1 alongside the instruction, with `WB_valid`=1 and `WB_mem_rdata`=0.
- Undefined: the `WB_misalign` port is absent and misaligned accesses behave as above (truncated lanes).

Decomposition:
- Shared package (rv32i_types):
  - funct3 load/store enum (lb, lh, lw, lbu, lhu, sb, sh, sw).
  - FSM state enum.
  - Width constants.
- One sub-module: mem_lane_align. It is combinational and produces byte_enable, wdata shift and load extraction/extension. The FSM and WB register stay in the top.

Test Plan:
- lw addr 0x100, `dmem_resp` 2 cycles later with rdata 0xDEADBEEF, `load`=1 → `stall` high 2 cycles, `dmem_read`=1 with addr 0x100, then `WB_mem_rdata`=0xDEADBEEF and `WB_valid`=1.
- sb addr 0x203, rs2=0x000000A5, resp same cycle → `dmem_write`=1, `dmem_address`=0x200, `byte_enable`=1000, `wdata`=0xA5000000, zero stall.
- lb / lbu addr 0x301 with rdata 0x0000_80_00 → `WB_mem_rdata` 0xFFFFFF80 for lb, 0x00000080 for lbu; lh addr 0x302 with rdata 0x8001_0000 → 0xFFFF8001.
- `dmem_resp` while `load`=0 for 3 cycles → FSM in HOLD, request deasserted, WB unchanged; on `load`=1 `WB_mem_rdata` equals the held value.
- `flush`=1 on a load in IDLE → no request and `WB_valid`=0; flush asserted mid-REQ → request completes and `WB_valid`=0; reset mid-REQ → all outputs 0 next cycle.
- MEM_MISALIGN_TRAP_EN defined, lw addr 0x102 → no `dmem_read`, `WB_misalign`=1; with the macro undefined, the same access issues a read to 0x100.

Source files
------------

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types for the memory-access stage: funct3 encodings, FSM states, widths
package rv32i_types;

    localparam int XLEN       = 32;
    localparam int BYTE_LANES = XLEN / 8;

    // Loads and stores reuse the same funct3 codes, so they get separate enums.
    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_HOLD = 2'b10
    } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - combinational byte-lane steering for stores and load extraction/extension
module mem_lane_align
    import rv32i_types::*;
(
    input  logic [2:0]            funct3,
    input  logic [1:0]            offset,
    input  logic [XLEN-1:0]       store_data,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic [BYTE_LANES-1:0] byte_enable,
    output logic [XLEN-1:0]       wdata,
    output logic [XLEN-1:0]       load_data
);

    logic [XLEN-1:0] shifted;

    assign wdata   = store_data << {offset, 3'b000};
    assign shifted = mem_rdata >> {offset, 3'b000};

    // A 4-bit shift silently drops lanes pushed past the top of the word.
    always_comb begin
        byte_enable = 4'b1111;
        case (funct3)
            F3_SB:   byte_enable = 4'b0001 << offset;
            F3_SH:   byte_enable = 4'b0011 << offset;
            default: byte_enable = 4'b1111;
        endcase
    end

    always_comb begin
        load_data = mem_rdata;
        case (funct3)
            F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   load_data = mem_rdata;
            F3_LBU:  load_data = {24'd0, shifted[7:0]};
            F3_LHU:  load_data = {16'd0, shifted[15:0]};
            default: load_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: data-memory request FSM and MEM/WB register; option MEM_MISALIGN_TRAP_EN
module mem_access_stage
    import rv32i_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] MEM_pc,
    input  logic [ADDR_W-1:0] MEM_alu_out,
    input  logic [DATA_W-1:0] MEM_rs2_out,
    input  logic              MEM_mem_read,
    input  logic              MEM_mem_write,
    input  logic [2:0]        MEM_funct3,
    input  logic              flush,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [ADDR_W-1:0] dmem_address,
    output logic [3:0]        dmem_byte_enable,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_resp,
    output logic              stall,
    output logic [ADDR_W-1:0] WB_pc,
    output logic [ADDR_W-1:0] WB_alu_out,
    output logic [DATA_W-1:0] WB_mem_rdata,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              WB_misalign,
`endif
    output logic              WB_valid
);

    mem_state_t        state;
    logic [DATA_W-1:0] held_rdata;
    logic              flushed;
    logic              mem_op;
    logic              misalign;
    logic              req_needed;
    logic              wb_advance;
    logic [3:0]        lane_be;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_load;
    logic [DATA_W-1:0] rdata_sel;

    mem_lane_align u_lane_align (
        .funct3      (MEM_funct3),
        .offset      (MEM_alu_out[1:0]),
        .store_data  (MEM_rs2_out),
        .mem_rdata   (dmem_rdata),
        .byte_enable (lane_be),
        .wdata       (lane_wdata),
        .load_data   (lane_load)
    );

    assign mem_op = MEM_mem_read | MEM_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = mem_op &
                      (((MEM_funct3[1:0] == 2'b01) & MEM_alu_out[0]) |
                       ((MEM_funct3[1:0] == 2'b10) & (MEM_alu_out[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    // Once issued, a request stays up until its response regardless of flush.
    always_comb begin
        req_needed = 1'b0;
        case (state)
            ST_IDLE: req_needed = mem_op & ~flush & ~misalign;
            ST_REQ:  req_needed = 1'b1;
            default: req_needed = 1'b0;
        endcase
        if (reset)
            req_needed = 1'b0;
    end

    assign dmem_read        = req_needed & MEM_mem_read;
    assign dmem_write       = req_needed & MEM_mem_write & ~MEM_mem_read;
    assign dmem_address     = req_needed ? {MEM_alu_out[ADDR_W-1:2], 2'b00} : '0;
    assign dmem_byte_enable = dmem_write ? lane_be : 4'b0000;
    assign dmem_wdata       = dmem_write ? lane_wdata : '0;
    assign stall            = req_needed & ~dmem_resp;
    assign wb_advance       = load & ~stall;

    always_comb begin
        rdata_sel = '0;
        if (state == ST_HOLD)
            rdata_sel = held_rdata;
        else if (req_needed & dmem_resp & MEM_mem_read)
            rdata_sel = lane_load;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            held_rdata   <= '0;
            flushed      <= 1'b0;
            WB_pc        <= '0;
            WB_alu_out   <= '0;
            WB_mem_rdata <= '0;
            WB_valid     <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            WB_misalign  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_needed & ~dmem_resp)
                        state <= ST_REQ;
                    else if (req_needed & dmem_resp & ~load)
                        state <= ST_HOLD;
                end
                ST_REQ: begin
                    if (dmem_resp)
                        state <= load ? ST_IDLE : ST_HOLD;
                end
                ST_HOLD: begin
                    if (load)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (req_needed & dmem_resp)
                held_rdata <= MEM_mem_read ? lane_load : '0;

            // Remember a flush that arrives while the request is in flight.
            if (wb_advance)
                flushed <= 1'b0;
            else if (flush & (state != ST_IDLE || req_needed))
                flushed <= 1'b1;

            if (wb_advance) begin
                WB_pc        <= MEM_pc;
                WB_alu_out   <= MEM_alu_out;
                WB_mem_rdata <= rdata_sel;
                WB_valid     <= ~(flush | flushed);
`ifdef MEM_MISALIGN_TRAP_EN
                WB_misalign  <= misalign & ~flush;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [31:0] MEM_pc;
    logic [31:0] MEM_alu_out;
    logic [31:0] MEM_rs2_out;
    logic        MEM_mem_read;
    logic        MEM_mem_write;
    logic [2:0]  MEM_funct3;
    logic        flush;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        stall;
    logic [31:0] WB_pc;
    logic [31:0] WB_alu_out;
    logic [31:0] WB_mem_rdata;
    logic        WB_valid;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        WB_misalign;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk              (clk),
        .reset            (reset),
        .load             (load),
        .MEM_pc           (MEM_pc),
        .MEM_alu_out      (MEM_alu_out),
        .MEM_rs2_out      (MEM_rs2_out),
        .MEM_mem_read     (MEM_mem_read),
        .MEM_mem_write    (MEM_mem_write),
        .MEM_funct3       (MEM_funct3),
        .flush            (flush),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_wdata       (dmem_wdata),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .stall            (stall),
        .WB_pc            (WB_pc),
        .WB_alu_out       (WB_alu_out),
        .WB_mem_rdata     (WB_mem_rdata),
`ifdef MEM_MISALIGN_TRAP_EN
        .WB_misalign      (WB_misalign),
`endif
        .WB_valid         (WB_valid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        load = 1'b1; flush = 1'b0; MEM_mem_read = 1'b0; MEM_mem_write = 1'b0;
        MEM_funct3 = 3'b010; MEM_rs2_out = 32'h0; dmem_resp = 1'b0; dmem_rdata = 32'h0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] rs2);
        MEM_mem_read = rd; MEM_mem_write = wr; MEM_funct3 = f3;
        MEM_pc = pc; MEM_alu_out = addr; MEM_rs2_out = rs2;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear_inputs(); drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0);
        step(); step();
        checks++; if (dmem_read !== 1'b0 || dmem_write !== 1'b0) begin errors++; $display("FAIL reset_req got %b%b exp 00", dmem_read, dmem_write); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
        checks++; if ({WB_pc, WB_alu_out, WB_mem_rdata} !== 96'h0 || WB_valid !== 1'b0) begin errors++; $display("FAIL reset_wb got %h %h %h %b exp 0", WB_pc, WB_alu_out, WB_mem_rdata, WB_valid); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_lw_stall();
        drive(1'b1, 1'b0, 3'b010, 32'h40, 32'h100, 32'h0);
        #1;
        checks++; if (dmem_read !== 1'b1 || dmem_address !== 32'h100 || dmem_write !== 1'b0) begin errors++; $display("FAIL lw_req got rd=%b wr=%b a=%h exp rd=1 wr=0 a=100", dmem_read, dmem_write, dmem_address); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lw_stall_c0 got %b exp 1", stall); end
        step();
        checks++; if (stall !== 1'b1 || dmem_read !== 1'b1) begin errors++; $display("FAIL lw_stall_c1 got stall=%b rd=%b exp 1 1", stall, dmem_read); end
        checks++; if (WB_pc !== 32'h0) begin errors++; $display("FAIL lw_wb_frozen got %h exp 0", WB_pc); end
        step();
        dmem_resp = 1'b1; dmem_rdata = 32'hDEADBEEF;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lw_stall_resp got %b exp 0", stall); end
        step();
        clear_inputs(); drive(1'b0, 1'b0, 3'b010, 32'h44, 32'h0, 32'h0);
        checks++; if (WB_mem_rdata !== 32'hDEADBEEF || WB_valid !== 1'b1 || WB_pc !== 32'h40) begin errors++; $display("FAIL lw_wb got %h v=%b pc=%h exp deadbeef 1 40", WB_mem_rdata, WB_valid, WB_pc); end
        #1;
        checks++; if (dmem_read !== 1'b0) begin errors++; $display("FAIL lw_idle_after got %b exp 0", dmem_read); end
    endtask

    task automatic test_sb_zero_stall();
        drive(1'b0, 1'b1, 3'b000, 32'h48, 32'h203, 32'h000000A5);
        dmem_resp = 1'b1;
        #1;
        checks++; if (dmem_write !== 1'b1 || dmem_read !== 1'b0 || dmem_address !== 32'h200) begin errors++; $display("FAIL sb_req got wr=%b rd=%b a=%h exp 1 0 200", dmem_write, dmem_read, dmem_address); end
        checks++; if (dmem_byte_enable !== 4'b1000 || dmem_wdata !== 32'hA5000000) begin errors++; $display("FAIL sb_lanes got be=%b wd=%h exp 1000 a5000000", dmem_byte_enable, dmem_wdata); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_stall got %b exp 0", stall); end
        step();
        clear_inputs();
        checks++; if (WB_pc !== 32'h48 || WB_alu_out !== 32'h203 || WB_mem_rdata !== 32'h0 || WB_valid !== 1'b1) begin errors++; $display("FAIL sb_wb got pc=%h alu=%h rd=%h v=%b exp 48 203 0 1", WB_pc, WB_alu_out, WB_mem_rdata, WB_valid); end
    endtask

    task automatic one_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        drive(1'b1, 1'b0, f3, 32'h50, addr, 32'h0);
        dmem_resp = 1'b1; dmem_rdata = rdata;
        step();
        clear_inputs();
    endtask

    task automatic test_load_format();
        one_load(3'b000, 32'h301, 32'h00008000);
        checks++; if (WB_mem_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext got %h exp ffffff80", WB_mem_rdata); end
        one_load(3'b100, 32'h301, 32'h00008000);
        checks++; if (WB_mem_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_zext got %h exp 00000080", WB_mem_rdata); end
        one_load(3'b001, 32'h302, 32'h80010000);
        checks++; if (WB_mem_rdata !== 32'hFFFF8001) begin errors++; $display("FAIL lh_sext got %h exp ffff8001", WB_mem_rdata); end
        one_load(3'b101, 32'h302, 32'h80010000);
        checks++; if (WB_mem_rdata !== 32'h00008001) begin errors++; $display("FAIL lhu_zext got %h exp 00008001", WB_mem_rdata); end
    endtask

    task automatic test_hold();
        load = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 32'h60, 32'h104, 32'h0);
        step();
        dmem_resp = 1'b1; dmem_rdata = 32'h12345678;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hold_resp_stall got %b exp 0", stall); end
        step();
        dmem_resp = 1'b0; dmem_rdata = 32'hFFFFFFFF;
        #1;
        checks++; if (dmem_read !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL hold_deassert got rd=%b st=%b exp 0 0", dmem_read, stall); end
        step(); step();
        checks++; if (WB_pc !== 32'h50 || WB_mem_rdata !== 32'h00008001) begin errors++; $display("FAIL hold_wb_unchanged got pc=%h rd=%h exp 50 00008001", WB_pc, WB_mem_rdata); end
        load = 1'b1;
        step();
        clear_inputs();
        checks++; if (WB_mem_rdata !== 32'h12345678 || WB_pc !== 32'h60 || WB_valid !== 1'b1) begin errors++; $display("FAIL hold_release got rd=%h pc=%h v=%b exp 12345678 60 1", WB_mem_rdata, WB_pc, WB_valid); end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b0, 3'b010, 32'h70, 32'h100, 32'h0);
        flush = 1'b1;
        #1;
        checks++; if (dmem_read !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL flush_idle_req got rd=%b st=%b exp 0 0", dmem_read, stall); end
        step();
        checks++; if (WB_valid !== 1'b0 || WB_pc !== 32'h70) begin errors++; $display("FAIL flush_idle_wb got v=%b pc=%h exp 0 70", WB_valid, WB_pc); end
        flush = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 32'h74, 32'h108, 32'h0);
        step();
        flush = 1'b1;
        #1;
        checks++; if (dmem_read !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL flush_mid_req got rd=%b st=%b exp 1 1", dmem_read, stall); end
        step();
        flush = 1'b0; dmem_resp = 1'b1; dmem_rdata = 32'h00000055;
        step();
        clear_inputs();
        checks++; if (WB_valid !== 1'b0 || WB_pc !== 32'h74 || WB_mem_rdata !== 32'h55) begin errors++; $display("FAIL flush_mid_wb got v=%b pc=%h rd=%h exp 0 74 55", WB_valid, WB_pc, WB_mem_rdata); end
    endtask

    task automatic test_reset_mid_req();
        drive(1'b1, 1'b0, 3'b010, 32'h80, 32'h10C, 32'h0);
        step();
        reset = 1'b1;
        step();
        checks++; if (dmem_read !== 1'b0 || stall !== 1'b0 || dmem_address !== 32'h0) begin errors++; $display("FAIL rst_mid_req got rd=%b st=%b a=%h exp 0 0 0", dmem_read, stall, dmem_address); end
        checks++; if (WB_pc !== 32'h0 || WB_mem_rdata !== 32'h0 || WB_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_wb got pc=%h rd=%h v=%b exp 0 0 0", WB_pc, WB_mem_rdata, WB_valid); end
        reset = 1'b0;
        clear_inputs();
        step();
        checks++; if (dmem_read !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got rd=%b st=%b exp 0 0", dmem_read, stall); end
    endtask

    task automatic test_non_mem();
        drive(1'b0, 1'b0, 3'b010, 32'h90, 32'h77, 32'h0);
        #1;
        checks++; if (dmem_read !== 1'b0 || dmem_write !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL nonmem_req got rd=%b wr=%b st=%b exp 0 0 0", dmem_read, dmem_write, stall); end
        step();
        checks++; if (WB_alu_out !== 32'h77 || WB_mem_rdata !== 32'h0 || WB_valid !== 1'b1) begin errors++; $display("FAIL nonmem_wb got alu=%h rd=%h v=%b exp 77 0 1", WB_alu_out, WB_mem_rdata, WB_valid); end
    endtask

    task automatic test_back_to_back();
        one_load(3'b010, 32'h10, 32'h11111111);
        checks++; if (WB_mem_rdata !== 32'h11111111 || WB_alu_out !== 32'h10) begin errors++; $display("FAIL b2b_first got rd=%h alu=%h exp 11111111 10", WB_mem_rdata, WB_alu_out); end
        one_load(3'b010, 32'h14, 32'h22222222);
        checks++; if (WB_mem_rdata !== 32'h22222222 || WB_alu_out !== 32'h14) begin errors++; $display("FAIL b2b_second got rd=%h alu=%h exp 22222222 14", WB_mem_rdata, WB_alu_out); end
    endtask

    task automatic test_misalign();
        drive(1'b1, 1'b0, 3'b010, 32'hA0, 32'h102, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
        #1;
        checks++; if (dmem_read !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL misalign_trap_req got rd=%b st=%b exp 0 0", dmem_read, stall); end
        step();
        clear_inputs();
        checks++; if (WB_misalign !== 1'b1 || WB_valid !== 1'b1 || WB_mem_rdata !== 32'h0) begin errors++; $display("FAIL misalign_trap_wb got m=%b v=%b rd=%h exp 1 1 0", WB_misalign, WB_valid, WB_mem_rdata); end
        drive(1'b0, 1'b1, 3'b001, 32'hA4, 32'h203, 32'h0000BEEF);
        #1;
        checks++; if (dmem_write !== 1'b0) begin errors++; $display("FAIL misalign_trap_sh got %b exp 0", dmem_write); end
        step();
        clear_inputs();
`else
        dmem_resp = 1'b1; dmem_rdata = 32'hAABBCCDD;
        #1;
        checks++; if (dmem_read !== 1'b1 || dmem_address !== 32'h100) begin errors++; $display("FAIL misalign_lw_req got rd=%b a=%h exp 1 100", dmem_read, dmem_address); end
        step();
        clear_inputs();
        checks++; if (WB_mem_rdata !== 32'hAABBCCDD) begin errors++; $display("FAIL misalign_lw_wb got %h exp aabbccdd", WB_mem_rdata); end
        drive(1'b0, 1'b1, 3'b001, 32'hA4, 32'h203, 32'h0000BEEF);
        dmem_resp = 1'b1;
        #1;
        checks++; if (dmem_byte_enable !== 4'b1000 || dmem_wdata !== 32'hEF000000) begin errors++; $display("FAIL misalign_sh_lanes got be=%b wd=%h exp 1000 ef000000", dmem_byte_enable, dmem_wdata); end
        step();
        clear_inputs();
`endif
    endtask

    initial begin
        test_reset();
        test_lw_stall();
        test_sb_zero_stall();
        test_load_format();
        test_hold();
        test_flush();
        test_reset_mid_req();
        test_non_mem();
        test_back_to_back();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
